pattern_match_ctrl: RTL and testbench

Run controller for serial bit-pattern detection. It arms a programmable Moore-style pattern detector for a fixed window of valid input samples and counts matches inside that window. It reports completion through a done/ack handshake. It sits between a serial bit source and a host or sequencer that configures the pattern, starts a measurement run and collects the match count.

---
 rtl/pattern_match_pkg.sv | 17 +
 rtl/pattern_match_ctrl_det_core.sv | 66 ++++++
 rtl/pattern_match_ctrl.sv | 123 ++++++++++++
 tb/tb_pattern_match_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_match_pkg.sv
// pattern_match_pkg
//   Shared definitions for the pattern match run controller:
//   - controller state encoding (IDLE, RUN, DONE), 2 bits
//   - default widths for pattern, match counter and window fields
package pattern_match_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/pattern_match_ctrl_det_core.sv
// pattern_det_core
//   History shift register, fill counter and pattern comparator.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset
//     clr         - clear history and fill counter
//     shift       - take bit_in into the history LSB this cycle
//     bit_in      - serial data bit
//     pattern     - target pattern, MSB is the oldest bit
//     hit         - combinational: the candidate next history is full and
//                   equals pattern (only while shift is high)
//   Build option:
//     OVERLAP_EN  - when defined, history and fill survive a hit so the bits
//                   of one match can start the next; otherwise the fill
//                   counter restarts after every hit.
module pattern_det_core
  import pattern_match_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_nxt;
  logic [FILL_W-1:0] fill_q, fill_d, fill_nxt;

  always_comb begin
    hist_nxt = {hist_q[PAT_W-2:0], bit_in};
    fill_nxt = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    hit      = shift && (fill_nxt == FILL_FULL) && (hist_nxt == pattern);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_nxt;
`ifdef OVERLAP_EN
      fill_d = fill_nxt;
`else
      // a hit consumes its bits: the next match needs PAT_W fresh samples
      fill_d = hit ? '0 : fill_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl
//   Run controller for serial bit-pattern detection. A start in IDLE latches
//   the pattern and window, then counts pattern matches over cfg_window valid
//   samples and reports completion with a done/done_ack handshake.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset
//     cfg_pattern  - target pattern (MSB oldest), latched on accepted start
//     cfg_window   - valid samples per run, latched on accepted start
//     start        - run request, accepted only in IDLE
//     din/din_valid- serial data and qualifier (used only in RUN)
//     busy         - high in RUN
//     match        - one-cycle pulse per detected match
//     match_count  - matches in current/last run, saturating
//     done         - high in DONE until done_ack
//     done_ack     - host acknowledge
//   Build option:
//     OVERLAP_EN   - overlapping detection (see pattern_det_core)
//
//   state   | meaning
//   IDLE    | waiting for start; match_count holds last result
//   RUN     | sampling din on din_valid, counting matches
//   DONE    | window complete; done high until done_ack
module pattern_match_ctrl
  import pattern_match_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  input  logic             done_ack
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [WIN_W-1:0] rem_q, rem_d;   // valid samples still to take this run
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;

  logic core_clr, core_shift, core_hit;

  pattern_det_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (core_clr),
    .shift   (core_shift),
    .bit_in  (din),
    .pattern (pat_q),
    .hit     (core_hit)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    match_d    = 1'b0;
    core_clr   = 1'b0;
    core_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d    = cfg_pattern;
          rem_d    = cfg_window;
          cnt_d    = '0;
          core_clr = 1'b1;
          state_d  = (cfg_window == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (din_valid) begin
          core_shift = 1'b1;
          if (core_hit) begin
            match_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
          rem_d = rem_q - 1'b1;
          // terminal count: this valid sample is the last of the window
          if (rem_q == WIN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign match       = match_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
module tb_pattern_match_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, din, din_valid, done_ack;
  logic [3:0]  cfg_pattern;
  logic [15:0] cfg_window;

  logic       busy_a, match_a, done_a;
  logic [7:0] cnt_a;
  logic       busy_b, match_b, done_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  // Default geometry: PAT_W=4, CNT_W=8
  pattern_match_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_window(cfg_window),
    .start(start), .din(din), .din_valid(din_valid), .busy(busy_a), .match(match_a),
    .match_count(cnt_a), .done(done_a), .done_ack(done_ack));

  // Small geometry for saturation: PAT_W=2, CNT_W=2
  pattern_match_ctrl #(.PAT_W(2), .CNT_W(2), .WIN_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern[1:0]), .cfg_window(cfg_window),
    .start(start), .din(din), .din_valid(din_valid), .busy(busy_b), .match(match_b),
    .match_count(cnt_b), .done(done_b), .done_ack(done_ack));

`ifdef OVERLAP_EN
  localparam bit OVL    = 1'b1;
  localparam int EXP_T3 = 2;
`else
  localparam bit OVL    = 1'b0;
  localparam int EXP_T3 = 1;
`endif

  typedef struct {
    logic m;
    int   cnt;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  int sel    = 0;   // 0: checking u_dut_a, 1: checking u_dut_b

  // reference model of the selected instance
  int m_state, m_pat, m_rem, m_hist, m_fill, m_cnt;
  bit m_m;

  function automatic int pw();   return (sel != 0) ? 2 : 4;   endfunction
  function automatic int cmax(); return (sel != 0) ? 3 : 255; endfunction

  function automatic logic [31:0] o_m();    return (sel != 0) ? {31'd0, match_b} : {31'd0, match_a}; endfunction
  function automatic logic [31:0] o_busy(); return (sel != 0) ? {31'd0, busy_b}  : {31'd0, busy_a};  endfunction
  function automatic logic [31:0] o_done(); return (sel != 0) ? {31'd0, done_b}  : {31'd0, done_a};  endfunction
  function automatic logic [31:0] o_cnt();  return (sel != 0) ? {30'd0, cnt_b}   : {24'd0, cnt_a};   endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pat = 0; m_rem = 0; m_hist = 0; m_fill = 0; m_cnt = 0; m_m = 0;
  endtask

  task automatic model_step(input bit st, input bit v, input bit d, input bit ack);
    exp_t e;
    int   mask;
    mask = (1 << pw()) - 1;
    m_m  = 0;
    if (m_state == 0) begin
      if (st) begin
        m_pat   = int'(cfg_pattern) & mask;
        m_rem   = int'(cfg_window);
        m_cnt   = 0;
        m_hist  = 0;
        m_fill  = 0;
        m_state = (cfg_window == 16'd0) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      if (v) begin
        m_hist = ((m_hist << 1) | int'(d)) & mask;
        if (m_fill < pw()) m_fill++;
        if (m_fill == pw() && m_hist == m_pat) begin
          m_m = 1;
          if (m_cnt < cmax()) m_cnt++;
          if (!OVL) m_fill = 0;
        end
        m_rem--;
        if (m_rem == 0) m_state = 2;
      end
    end else begin
      if (ack) m_state = 0;
    end
    e.m    = m_m;
    e.cnt  = m_cnt;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    sb.push_back(e);
  endtask

  task automatic cycle(input bit st, input bit v, input bit d, input bit ack, input string tag);
    exp_t e;
    start = st; din_valid = v; din = d; done_ack = ack;
    model_step(st, v, d, ack);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".match"}, o_m(),    {31'd0, e.m});
    chk({tag, ".count"}, o_cnt(),  e.cnt);
    chk({tag, ".busy"},  o_busy(), {31'd0, e.busy});
    chk({tag, ".done"},  o_done(), {31'd0, e.done});
    start = 0; din_valid = 0; din = 0; done_ack = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1; start = 0; din_valid = 0; din = 0; done_ack = 0;
    @(posedge clk);
    #1;
    model_reset();
    chk({tag, ".busy"},  o_busy(), 0);
    chk({tag, ".done"},  o_done(), 0);
    chk({tag, ".match"}, o_m(),    0);
    chk({tag, ".count"}, o_cnt(),  0);
    reset = 0;
  endtask

  initial begin
    bit t3_bits [7] = '{1, 0, 0, 1, 0, 0, 1};
    bit t5_st   [8] = '{0, 1, 0, 0, 1, 0, 0, 1};
    bit t5_v    [8] = '{1, 0, 0, 1, 0, 1, 0, 1};
    bit t5_d    [8] = '{1, 0, 0, 0, 0, 1, 0, 1};

    reset = 1; start = 0; din = 0; din_valid = 0; done_ack = 0;
    cfg_pattern = '0; cfg_window = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset state, then abort a run part way through
    sel = 0;
    do_reset("rst_init");
    cfg_pattern = 4'b1001; cfg_window = 16'd7;
    cycle(1, 0, 0, 0, "rst_mid.start");
    cycle(0, 1, 1, 0, "rst_mid.s1");
    cycle(0, 1, 0, 0, "rst_mid.s2");
    cycle(0, 1, 0, 0, "rst_mid.s3");
    do_reset("rst_mid.abort");
    cycle(0, 0, 0, 0, "rst_mid.idle");

    // pattern 1001, window 7, stream 1001001
    cfg_pattern = 4'b1001; cfg_window = 16'd7;
    cycle(1, 0, 0, 0, "p1001.start");
    for (int i = 0; i < 7; i++) cycle(0, 1, t3_bits[i], 0, $sformatf("p1001.s%0d", i + 1));
    chk("p1001.final_count", o_cnt(), EXP_T3);
    chk("p1001.final_done", o_done(), 1);
    cycle(0, 0, 0, 0, "p1001.hold");
    cycle(0, 0, 0, 1, "p1001.ack");
    cycle(0, 0, 0, 0, "p1001.idle");

    // zero window goes straight to DONE
    cfg_window = 16'd0;
    cycle(1, 0, 0, 0, "win0.start");
    chk("win0.done", o_done(), 1);
    cycle(0, 0, 0, 0, "win0.hold");
    cycle(0, 0, 0, 1, "win0.ack");

    // gapped valid with start pulses during RUN
    do_reset("gap.rst");
    cfg_pattern = 4'b1011; cfg_window = 16'd4;
    cycle(1, 0, 0, 0, "gap.start");
    cfg_pattern = 4'b0000; cfg_window = 16'd1;
    for (int i = 0; i < 8; i++) cycle(t5_st[i], t5_v[i], t5_d[i], 0, $sformatf("gap.c%0d", i));
    chk("gap.final_count", o_cnt(), 1);
    chk("gap.final_done", o_done(), 1);
    cycle(0, 0, 0, 1, "gap.ack");

    // saturation on the 2-bit counter instance
    sel = 1;
    do_reset("sat.rst");
    cfg_pattern = 4'b0011; cfg_window = 16'd8;
    cycle(1, 0, 0, 0, "sat.start");
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, $sformatf("sat.s%0d", i + 1));
    chk("sat.final_count", o_cnt(), 3);
    chk("sat.final_done", o_done(), 1);
    cycle(1, 0, 0, 1, "sat.ack_start");
    cycle(0, 0, 0, 0, "sat.idle");
    chk("sat.kept_count", o_cnt(), 3);
    cycle(1, 0, 0, 0, "sat.restart");
    chk("sat.cleared", o_cnt(), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, $sformatf("sat.r%0d", i + 1));

    // random stream against the model
    sel = 0;
    do_reset("rnd.rst");
    cfg_pattern = 4'($urandom_range(0, 15)); cfg_window = 16'd20;
    cycle(1, 0, 0, 0, "rnd.start");
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            0, $sformatf("rnd.c%0d", i));
    cycle(0, 0, 0, 1, "rnd.ack");
    cycle(0, 0, 0, 0, "rnd.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
